// File: rtl/spi_slave_frontend_if.sv
// Link- and FSM-side signal bundle for spi_slave_frontend.
// Handshake: rdy_spi=1 means rx_output holds an unfetched frame; the consumer pulses ack_fetch_spi for one clk (only while spi_busy=0) and rdy_spi drops on the following clk; push_tx qualifies tx_input and is accepted only while the slave is idle.
`timescale 1ns/1ps
interface spi_slave_frontend_if #(
  parameter int LEN_SPI = 32
);
  logic               sclk;
  logic               cs_n;
  logic               mosi;
  logic               miso;
  logic               miso_oe;
  logic [LEN_SPI-1:0] rx_output;
  logic               rdy_spi;
  logic               spi_busy;
  logic               ack_fetch_spi;
  logic [LEN_SPI-1:0] tx_input;
  logic               push_tx;
  logic               overrun;

  modport slave (
    input  sclk, cs_n, mosi, ack_fetch_spi, tx_input, push_tx,
    output miso, miso_oe, rx_output, rdy_spi, spi_busy, overrun
  );

  modport master (
    output sclk, cs_n, mosi, ack_fetch_spi, tx_input, push_tx,
    input  miso, miso_oe, rx_output, rdy_spi, spi_busy, overrun
  );
endinterface

// File: rtl/spi_slave_frontend.sv
// SPI mode-0 slave front-end: oversampled link, 32-bit frame deserialiser, response serialiser.
// Optional macro SPI_STRICT_FRAME_EN defers the commit to cs_n rising and drops frames that are not exactly LEN_SPI bits.
`timescale 1ns/1ps
module spi_slave_frontend #(
  parameter int LEN_SPI     = 32,
  parameter int CNT_W       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_slave_frontend_if.slave  bus,
  output logic [1:0]           state_dbg_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

`ifdef SPI_STRICT_FRAME_EN
  localparam int RX_W = LEN_SPI;
`else
  localparam int RX_W = LEN_SPI - 1;
`endif

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  state_e             state_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [RX_W-1:0]    rx_shift_q;
  logic [LEN_SPI-1:0] tx_shift_q;
  logic [LEN_SPI-1:0] tx_hold_q;
`ifdef SPI_STRICT_FRAME_EN
  logic               long_q;
`endif

  logic [LEN_SPI-1:0] rx_output_q, rx_output_d;
  logic               rdy_q, rdy_d;
  logic               overrun_q, overrun_d;

  logic               last_bit;
  logic [LEN_SPI-1:0] shift_in;
  logic               commit;
  logic [LEN_SPI-1:0] commit_frame;

  // cs_n synchroniser resets to the deselected level so no false cs_fall appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  assign last_bit = (bit_cnt_q == CNT_W'(LEN_SPI - 1));
  assign shift_in = {rx_shift_q[LEN_SPI-2:0], mosi_s};

  // The sclk_rise carrying the final bit commits the frame including that bit.
  always_comb begin
    commit       = 1'b0;
    commit_frame = shift_in;
`ifdef SPI_STRICT_FRAME_EN
    if (state_q == ST_SHIFT && sclk_rise && last_bit && cs_rise) begin
      commit = 1'b1;
    end else if (state_q == ST_DONE && cs_rise && !long_q && !sclk_rise) begin
      commit       = 1'b1;
      commit_frame = rx_shift_q;
    end
`else
    if (state_q == ST_SHIFT && sclk_rise && last_bit) begin
      commit = 1'b1;
    end
`endif
  end

  // A commit outranks an ack in the same clk; overrun only flags a frame lost unfetched.
  always_comb begin
    rx_output_d = commit ? commit_frame : rx_output_q;
    rdy_d       = rdy_q;
    overrun_d   = overrun_q;
    if (bus.ack_fetch_spi) begin
      rdy_d     = 1'b0;
      overrun_d = 1'b0;
    end
    if (commit) begin
      rdy_d = 1'b1;
      if (rdy_q && !bus.ack_fetch_spi) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_output_q <= '0;
      rdy_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_output_q <= rx_output_d;
      rdy_q       <= rdy_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_hold_q <= '0;
    end else if (bus.push_tx && state_q == ST_IDLE) begin
      tx_hold_q <= bus.tx_input;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
`ifdef SPI_STRICT_FRAME_EN
      long_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_q    <= ST_SHIFT;
            bit_cnt_q  <= '0;
            tx_shift_q <= tx_hold_q;
`ifdef SPI_STRICT_FRAME_EN
            long_q     <= 1'b0;
`endif
          end
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            rx_shift_q <= shift_in[RX_W-1:0];
            bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
          end
          if (sclk_fall) begin
            tx_shift_q <= {tx_shift_q[LEN_SPI-2:0], 1'b0};
          end
          if (cs_rise) begin
            state_q <= ST_IDLE;
          end else if (sclk_rise && last_bit) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
`ifdef SPI_STRICT_FRAME_EN
          if (sclk_rise) begin
            long_q <= 1'b1;
          end
`endif
          if (cs_rise) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // miso is the MSB of the serialiser, so it is held whenever the shifter is frozen.
  assign bus.miso      = tx_shift_q[LEN_SPI-1];
  assign bus.miso_oe   = ~cs_s;
  assign bus.rx_output = rx_output_q;
  assign bus.rdy_spi   = rdy_q;
  assign bus.spi_busy  = (state_q != ST_IDLE);
  assign bus.overrun   = overrun_q;
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_spi_slave_frontend.sv
// Directed and randomized frames for spi_slave_frontend checked against a frame-level model.
`timescale 1ns/1ps
module tb_spi_slave_frontend;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;

  spi_slave_frontend_if #(.LEN_SPI(32)) bus ();

  spi_slave_frontend #(
    .LEN_SPI     (32),
    .CNT_W       (6),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // 38.4 MHz system clock, approximated as 26 ns.
  initial clk = 1'b0;
  always #13 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model_tx  = '0;
  logic [31:0] exp_rx    = '0;
  logic        exp_rdy   = 1'b0;
  logic        exp_ovr   = 1'b0;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] v);
    bus.tx_input = v;
    bus.push_tx  = 1'b1;
    wait_clks(1);
    bus.push_tx  = 1'b0;
    model_tx     = v;
  endtask

  task automatic ack_frame();
    bus.ack_fetch_spi = 1'b1;
    wait_clks(1);
    bus.ack_fetch_spi = 1'b0;
    exp_rdy = 1'b0;
    exp_ovr = 1'b0;
    chk("ack_rdy", bus.rdy_spi, exp_rdy);
    chk("ack_overrun", bus.overrun, exp_ovr);
    chk("ack_rx_stable", bus.rx_output, exp_rx);
  endtask

  // Mode 0 master at clk/8: mosi set while sclk low, miso sampled just before sclk rises.
  task automatic run_frame(input logic [31:0] data, input int nbits);
    logic [31:0] miso_word;
    logic [31:0] exp_tx;
    bit          committed;
    int          n;
    exp_q.push_back(model_tx);
    miso_word = '0;
    bus.cs_n = 1'b0;
    wait_clks(4);
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = (i < 32) ? data[31-i] : 1'($urandom_range(0, 1));
      wait_clks(4);
      if (i == 0) begin
        chk("busy_mid", bus.spi_busy, 1);
        chk("miso_oe_mid", bus.miso_oe, 1);
      end
      if (i < 32) miso_word = {miso_word[30:0], bus.miso};
      bus.sclk = 1'b1;
      wait_clks(4);
      bus.sclk = 1'b0;
    end
    wait_clks(4);
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    wait_clks(8);

    exp_tx = exp_q.pop_front();
    n = (nbits < 32) ? nbits : 32;
    chk("miso_word", miso_word, exp_tx >> (32 - n));
`ifdef SPI_STRICT_FRAME_EN
    committed = (nbits == 32);
`else
    committed = (nbits >= 32);
`endif
    if (committed) begin
      if (exp_rdy) exp_ovr = 1'b1;
      exp_rdy = 1'b1;
      exp_rx  = data;
    end
    chk("rx_output", bus.rx_output, exp_rx);
    chk("rdy_spi", bus.rdy_spi, exp_rdy);
    chk("overrun", bus.overrun, exp_ovr);
    chk("busy_after", bus.spi_busy, 0);
    chk("miso_oe_after", bus.miso_oe, 0);
    chk("state_idle", state_dbg, 0);
  endtask

  initial begin
    logic [31:0] rdata;
    int          rbits;

    rst_n             = 1'b0;
    bus.sclk          = 1'b0;
    bus.cs_n          = 1'b1;
    bus.mosi          = 1'b0;
    bus.ack_fetch_spi = 1'b0;
    bus.tx_input      = '0;
    bus.push_tx       = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(4);

    chk("rst_rx", bus.rx_output, 0);
    chk("rst_rdy", bus.rdy_spi, 0);
    chk("rst_busy", bus.spi_busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_miso_oe", bus.miso_oe, 0);
    chk("rst_miso", bus.miso, 0);
    chk("rst_state", state_dbg, 0);

    run_frame(32'h0A00_0000, 32);
    ack_frame();

    push_word(32'h0000_BEEF);
    run_frame(32'h2800_0000, 32);
    ack_frame();

    run_frame(32'($urandom()), 20);
    run_frame(32'h6400_0003, 32);
    ack_frame();

    run_frame(32'h0400_0001, 32);
    run_frame(32'h0800_0002, 32);
    ack_frame();

    push_word(32'hC3A5_5A3C);
    run_frame(32'h1234_5678, 33);
    if (exp_rdy) ack_frame();

    for (int k = 0; k < 12; k++) begin
      rdata = $urandom();
      case ($urandom_range(0, 3))
        0:       rbits = $urandom_range(1, 31);
        1:       rbits = $urandom_range(33, 36);
        default: rbits = 32;
      endcase
      if ($urandom_range(0, 1) == 1) push_word($urandom());
      run_frame(rdata, rbits);
      if (exp_rdy && $urandom_range(0, 1) == 1) ack_frame();
    end

    // Leave a frame unfetched, then reset in the middle of the next one.
    push_word(32'hFFFF_FFFF);
    run_frame(32'h5A5A_A5A5, 32);
    bus.cs_n = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 10; i++) begin
      bus.mosi = 1'($urandom_range(0, 1));
      wait_clks(4);
      bus.sclk = 1'b1;
      wait_clks(4);
      bus.sclk = 1'b0;
    end
    rst_n = 1'b0;
    wait_clks(1);
    chk("midrst_rx", bus.rx_output, 0);
    chk("midrst_rdy", bus.rdy_spi, 0);
    chk("midrst_busy", bus.spi_busy, 0);
    chk("midrst_overrun", bus.overrun, 0);
    chk("midrst_miso_oe", bus.miso_oe, 0);
    chk("midrst_miso", bus.miso, 0);
    chk("midrst_state", state_dbg, 0);
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(4);
    exp_rx   = '0;
    exp_rdy  = 1'b0;
    exp_ovr  = 1'b0;
    model_tx = '0;

    run_frame(32'h1357_2468, 32);
    ack_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_frontend.md
Name: spi_slave_frontend

Overview:
SPI slave front-end that terminates the external SPI link and feeds the chip FSM's command handshake. It oversamples sclk/cs_n/mosi in the clk domain (38.4 MHz) and deserialises 32-bit command frames onto rx_output with a rdy_spi/ack_fetch_spi handshake. It serialises the FSM's tx_input response onto miso during the next frame. It is the link-side counterpart of the FSM's rx_output/rdy_spi/spi_busy/ack_fetch_spi/tx_input/push_tx interface.

Parameters:
LEN_SPI, 32, frame length in bits (MSB first)
CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > LEN_SPI
SYNC_STAGES, 2, synchroniser depth for sclk, cs_n and mosi (minimum 2)

Ports:
clk  input  1  system clock, 38.4 MHz
rst_n  input  1  reset, asynchronous, active-low
sclk  input  1  SPI clock from external master, mode 0 (CPOL=0, CPHA=0); maximum frequency clk/8
cs_n  input  1  SPI chip select, active-low
mosi  input  1  serial data from master
miso  output  1  serial data to master
miso_oe  output  1  miso output enable; high while the synchronised cs_n is low
rx_output  output  LEN_SPI  received command frame
rdy_spi  output  1  rx_output holds a valid, unfetched frame
spi_busy  output  1  frame in progress (synchronised cs_n low)
ack_fetch_spi  input  1  FSM has fetched rx_output
tx_input  input  LEN_SPI  response word from FSM
push_tx  input  1  tx_input valid; load permitted
overrun  output  1  sticky flag: a frame was committed while rdy_spi was still high

Behaviour:
- Reset values: all outputs 0, except miso_oe=0 and miso=0. Synchronisers reset to sclk=0, cs_n=1, mosi=0. State = IDLE.
- Synchronisation and edge detection:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops, plus one extra flop on sclk and cs_n for edge detection.
  - Edge pulses (one clk wide): sclk_rise, sclk_fall, cs_fall, cs_rise.
- Response holding register tx_hold: loads tx_input on any clk where push_tx=1 and state==IDLE. It is frozen otherwise.
- State machine: IDLE, SHIFT, DONE.
  - IDLE, on cs_fall -> SHIFT:
    - bit_cnt=0
    - tx_shift=tx_hold
    - miso driven with tx_hold[LEN_SPI-1] in the same cycle the state changes
  - SHIFT, on sclk_rise:
    - rx_shift <= {rx_shift[LEN_SPI-2:0], mosi_sync}
    - bit_cnt increments
  - SHIFT, on sclk_fall: tx_shift shifts left one bit; miso = new tx_shift MSB.
  - SHIFT, when bit_cnt reaches LEN_SPI: commit the frame (see below) -> DONE.
  - SHIFT, on cs_rise before LEN_SPI bits: partial frame discarded, no commit -> IDLE.
  - DONE: further sclk edges are ignored and miso is held. On cs_rise -> IDLE.
- Commit:
  - rx_output <= assembled frame, one clk after the sclk_rise carrying bit LEN_SPI.
  - rdy_spi <= 1 on the same clk.
- Handshake:
  - rdy_spi stays high until ack_fetch_spi=1 is sampled on posedge clk; it clears on the next clk.
  - rx_output is unchanged after ack and remains stable until the next commit.
  - The FSM fetches only when spi_busy=0, so a frame is fetched after cs_n deasserts.
- spi_busy = state != IDLE.
- Overrun: if a commit occurs while rdy_spi=1 (not yet acked):
  - rx_output is overwritten and rdy_spi stays 1.
  - overrun is set, and clears on the clk after ack_fetch_spi is sampled.
- Simultaneous events:
  - ack_fetch_spi and a commit in the same clk: the commit wins; rdy_spi stays 1 and overrun is not set.
  - cs_rise in the same clk as the final sclk_rise: the frame is committed, then -> IDLE.
- Asynchronous reset mid-frame: the frame is lost and all outputs return to reset values.

Optional Feature:
Macro SPI_STRICT_FRAME_EN.
- Defined:
  - The commit is deferred to the cs_rise that ends the frame, and only if exactly LEN_SPI bits were received.
  - Any sclk_rise in DONE marks the frame long, and it is discarded.
  - rdy_spi asserts one clk after cs_rise.
- Undefined: the commit occurs at the LEN_SPI-th bit as described above, and extra bits are ignored.

Test Plan:
- Reset, then idle: rx_output=0, rdy_spi=0, spi_busy=0, overrun=0, miso_oe=0.
- Send frame 0x0A00_0000 (code 2) at sclk=4.8 MHz -> rx_output=0x0A00_0000, rdy_spi=1; ack pulse -> rdy_spi=0 on the next clk, rx_output unchanged.
- tx_input=0x0000_BEEF with push_tx=1, then frame 0x2800_0000 -> miso bits sampled on sclk rise read 0x0000_BEEF MSB first.
- cs_n raised after 20 bits -> no commit, rdy_spi=0, state IDLE; the next full frame 0x6400_0003 is committed correctly.
- Two frames 0x0400_0001 then 0x0800_0002 with no ack -> rx_output=0x0800_0002, overrun=1; ack -> overrun=0, rdy_spi=0.
- 33-bit frame:
  - SPI_STRICT_FRAME_EN undefined: first 32 bits committed.
  - SPI_STRICT_FRAME_EN defined: nothing committed.
